fifo_uart_tx: RTL and testbench

Read-side consumer for the team's first-word-fall-through sync FIFO. It drains words from the FIFO read port (dout/empty/rden) and serializes each word as an asynchronous UART frame on a single line: start bit, LSB-first data, optional parity, then one stop bit. It sits between a syn_fifo instance and the board TX pin, and is the transmitting end for FIFO-buffered serial output.

---
 rtl/fifo_uart_tx.sv | 132 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO and sends each word as a UART frame:
// start bit, LSB-first data, optional parity, one stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a word in the FIFO
// START  | driving the start bit (0)
// DATA   | shifting data bits out, LSB first
// PARITY | driving the parity bit (only when PARITY_EN=1)
// STOP   | driving the stop bit (1); the last cycle may pop the next word
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rden,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_next;
    logic [BAUD_W-1:0]     baud_cnt, baud_next;
    logic [BIT_W-1:0]      bit_cnt, bit_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic                  parity, parity_next;
    logic                  tx_next, busy_next, frame_done_next;
    logic                  bit_end, load;

    assign bit_end = (state != IDLE) && (baud_cnt == BAUD_LAST);
    // A pop on the last STOP cycle chains the next frame with no idle gap.
    assign load    = rst && !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt;
        bit_next    = bit_cnt;
        shift_next  = shift;
        parity_next = parity;
        if (state != IDLE) begin
            baud_next = bit_end ? '0 : baud_cnt + 1'b1;
        end
        case (state)
            IDLE: ;
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            state_next  = START;
            baud_next   = '0;
            bit_next    = '0;
            shift_next  = fifo_dout;
            parity_next = (^fifo_dout) ^ (PARITY_ODD != 0);
        end
    end

    // Outputs are computed from next-state values so the registered copies line up with state.
    always_comb begin
        fifo_rden       = load;
        busy_next       = (state_next != IDLE);
        frame_done_next = (state_next == STOP) && (baud_next == BAUD_LAST);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            baud_cnt   <= baud_next;
            bit_cnt    <= bit_next;
            shift      <= shift_next;
            parity     <= parity_next;
            tx         <= tx_next;
            busy       <= busy_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity, even, odd) fed from FIFO models,
// with expected words queued at stimulus time and checked by per-instance line monitors.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;   // hand-computed even parity of d
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] dout  [3];
    logic       empty [3];
    logic       rden  [3];
    logic       tx    [3];
    logic       busy  [3];
    logic       fd    [3];

    logic [7:0] fq [3][$];
    exp_t       eq [3][$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int pops [3];
    int frames [3];
    int aborts [3];
    int b2b [3];
    int fall_cyc [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int PE  = (g > 0) ? 1 : 0;
        localparam int ODD = (g == 2) ? 1 : 0;
        localparam int L   = (10 + PE) * CPB;

        bit         pend;
        bit         in_frame;
        int         c;
        int         err;
        int         last_end = -100;
        int         exp_start;
        logic [10:0] fb;
        logic [7:0] got;
        exp_t       e;

        fifo_uart_tx #(
            .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(PE), .PARITY_ODD(ODD)
        ) u_dut (
            .clk(clk), .rst(rst), .fifo_dout(dout[g]), .fifo_empty(empty[g]),
            .fifo_rden(rden[g]), .tx(tx[g]), .busy(busy[g]), .frame_done(fd[g])
        );

        // FWFT FIFO model: pop what the DUT strobed, then present the new head.
        always @(negedge clk) begin
            if (pend) begin
                if (fq[g].size() > 0) void'(fq[g].pop_front());
                pops[g]++;
                pend = 1'b0;
            end
            if (fq[g].size() == 0) begin
                empty[g] = 1'b1;
            end else begin
                if (empty[g]) fall_cyc[g] = cyc;
                empty[g] = 1'b0;
                dout[g]  = fq[g][0];
            end
            #1 pend = (rden[g] === 1'b1);
        end

        always @(posedge clk) begin
            #1;
            if (!rst) begin
                if (in_frame) begin
                    aborts[g]++;
                    in_frame = 1'b0;
                end
                chk(tx[g] === 1'b1 && busy[g] === 1'b0 && fd[g] === 1'b0 && rden[g] === 1'b0,
                    $sformatf("reset_outputs[%0d] {tx,busy,done,rden}", g),
                    {tx[g], busy[g], fd[g], rden[g]}, 4'b1000);
            end else begin
                if (!in_frame) begin
                    if (tx[g] === 1'b0) begin
                        in_frame = 1'b1;
                        c = 0;
                        err = 0;
                        got = '0;
                        if (cyc == last_end + 1) begin
                            b2b[g]++;
                        end else begin
                            exp_start = ((fall_cyc[g] > rel_cyc) ? fall_cyc[g] : rel_cyc) + 1;
                            chk(cyc == exp_start, $sformatf("start_latency[%0d]", g), cyc, exp_start);
                        end
                        chk(eq[g].size() > 0, $sformatf("frame_expected[%0d]", g), eq[g].size(), 1);
                        e = (eq[g].size() > 0) ? eq[g].pop_front() : '0;
                        fb = '1;
                        fb[0] = 1'b0;
                        for (int i = 0; i < 8; i++) fb[1+i] = e.d[i];
                        if (PE == 1) fb[9] = e.pe ^ (ODD == 1);
                    end else begin
                        chk(busy[g] === 1'b0 && fd[g] === 1'b0 && rden[g] === !empty[g],
                            $sformatf("idle[%0d] {busy,done,rden}", g),
                            {busy[g], fd[g], rden[g]}, {2'b00, !empty[g]});
                    end
                end
                if (in_frame) begin
                    if (tx[g] !== fb[c/CPB]) err++;
                    if (busy[g] !== 1'b1) err++;
                    if (fd[g] !== (c == L-1)) err++;
                    if (rden[g] !== ((c == L-1) && !empty[g])) err++;
                    if (c >= CPB && c < 9*CPB && (c % CPB) == CPB/2) got[c/CPB - 1] = tx[g];
                    if (c == L-1) begin
                        chk(err == 0, $sformatf("frame_cycles[%0d] bad cycles", g), err, 0);
                        chk(got == e.d, $sformatf("frame_word[%0d]", g), got, e.d);
                        frames[g]++;
                        in_frame = 1'b0;
                        last_end = cyc;
                    end else begin
                        c++;
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic pe);
        exp_t x;
        x.d  = d;
        x.pe = pe;
        for (int k = 0; k < 3; k++) begin
            fq[k].push_back(d);
            eq[k].push_back(x);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0 &&
                   busy[0] === 1'b0 && busy[1] === 1'b0 && busy[2] === 1'b0;
        end
        chk(done, {"wait_idle_", name}, n, budget);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            empty[k] = 1'b1;
            dout[k]  = '0;
        end
        // Word waiting while reset is held: no pop, idle outputs.
        push(8'hA5, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        rel_cyc = cyc;
        wait_idle(200, "a5");

        push(8'h00, 1'b0);
        push(8'hFF, 1'b0);
        wait_idle(300, "00_ff");

        push(8'h07, 1'b1);
        wait_idle(200, "07");

        // Reset during the third data bit of 0x3C, then send 0x55.
        push(8'h3C, 1'b0);
        n = 0;
        while (busy[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(busy[0] === 1'b1, "abort_frame_started", n, 20);
        repeat (13) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rel_cyc = cyc;
        repeat (3) @(negedge clk);
        push(8'h55, 1'b0);
        wait_idle(200, "55");

        for (int k = 0; k < 3; k++) begin
            chk(pops[k] == 6, $sformatf("pop_count[%0d]", k), pops[k], 6);
            chk(frames[k] == 5, $sformatf("frames_done[%0d]", k), frames[k], 5);
            chk(aborts[k] == 1, $sformatf("aborted_frames[%0d]", k), aborts[k], 1);
            chk(b2b[k] == 1, $sformatf("back_to_back[%0d]", k), b2b[k], 1);
            chk(eq[k].size() == 0, $sformatf("expected_left[%0d]", k), eq[k].size(), 0);
        end

        // Long idle with an empty FIFO after a fresh reset.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rel_cyc = cyc;
        repeat (200) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk(pops[k] == 6, $sformatf("idle_no_pop[%0d]", k), pops[k], 6);
            chk(tx[k] === 1'b1 && busy[k] === 1'b0, $sformatf("idle_line[%0d] {tx,busy}", k),
                {tx[k], busy[k]}, 2'b10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
